mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum consecutive BUSY cycles per transaction before abort.
REQ-002 Parameter ERRWORD, default 32'hBAD1BAD1: load value returned on timeout abort.
REQ-003 CLK  in  1  system clock, rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 iREN  in  1  instruction read request from caches.
REQ-006 iaddr  in  32  instruction address.
REQ-007 iwait  out  1  low for exactly the completion cycle of an instruction read.
REQ-008 iload  out  32  instruction data, valid while iwait low.
REQ-009 dREN  in  1  data read request.
REQ-010 dWEN  in  1  data write request.
REQ-011 daddr  in  32  data address.
REQ-012 dstore  in  32  write data.
REQ-013 dwait  out  1  low for exactly the completion cycle of a data access.
REQ-014 dload  out  32  read data, valid while dwait low.
REQ-015 ramREN  out  1  RAM read strobe.
REQ-016 ramWEN  out  1  RAM write strobe.
REQ-017 ramaddr  out  32  RAM address.
REQ-018 ramstore  out  32  RAM write data.
REQ-019 ramload  in  32  RAM read data.
REQ-020 ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
REQ-021 ccerr  out  1  sticky error flag.

Function
REQ-022 FSM states IDLE, IREQ, DREQ; exactly one transaction outstanding.
REQ-023 IDLE: if dREN|dWEN, next state DREQ; else if iREN, next IREQ; else stay; grant decision registered, so minimum request-to-completion latency is 2 cycles.
REQ-024 On grant, address, store data and op (write if dWEN, else read; dWEN wins when both asserted) are registered; RAM outputs driven only from the registered copy.
REQ-025 IREQ/DREQ: ramREN/ramWEN held asserted per op until completion; in IDLE both strobes are 0 and ramaddr/ramstore 0.
REQ-026 Completion: in the cycle ramstate==ACCESS, the granted requester's wait is driven low combinationally, load = ramload, next state IDLE.
REQ-027 ramstate==ERROR in IREQ/DREQ: completes as REQ-026 and sets ccerr.
REQ-028 BUSY counter: 8-bit saturating, cleared on grant, increments each BUSY cycle; on reaching TIMEOUT, wait pulsed low with load=ERRWORD, ccerr set, next IDLE.
REQ-029 Requester withdraws (its REN/WEN low) before completion: abort, next IDLE, no wait pulse, ccerr unchanged.
REQ-030 Non-granted requester's wait stays 1 throughout; its load is 0.
REQ-031 A request held through its completion cycle is re-arbitrated in IDLE on the next cycle (back-to-back accesses allowed, one IDLE cycle between).
REQ-032 ccerr clears only on reset.

Reset
REQ-033 nRST low asynchronously forces IDLE, counter 0, ccerr 0, ramREN 0, ramWEN 0, ramaddr 0, ramstore 0, iwait 1, dwait 1, iload 0, dload 0, including mid-transaction; no completion is reported for the interrupted transaction.

Configuration
REQ-034 Macro ARB_FAIRNESS_EN defined: register last_d set on each data grant, cleared on each instruction grant; in IDLE with both pending and last_d=1, instruction is granted.
REQ-035 ARB_FAIRNESS_EN undefined: data always wins per REQ-023; last_d absent.

Verification
REQ-036 iREN=1, iaddr=0x100, ramstate BUSY 2 cycles then ACCESS with ramload=0x8C220004 -> iwait low one cycle, iload=0x8C220004, ramREN=1 only in IREQ.
REQ-037 iREN and dWEN together, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x200, ramstore=0xDEADBEEF first; dwait pulse; iwait stays 1 until subsequent IREQ completes.
REQ-038 ARB_FAIRNESS_EN defined, dREN and iREN held for 4 transactions -> grants alternate D,I,D,I; undefined -> D,D,D,D.
REQ-039 ramstate held BUSY, TIMEOUT=64 -> after 64 BUSY cycles dwait low, dload=0xBAD1BAD1, ccerr=1 until reset.
REQ-040 nRST asserted mid-DREQ -> ramREN/ramWEN 0 immediately, no dwait pulse, state IDLE, ccerr 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction and data requesters, data first by default.
// Define ARB_FAIRNESS_EN to alternate grants when both requesters are pending.
module mem_arbiter #(
    parameter int          TIMEOUT = 64,
    parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ccerr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IREQ = 2'd1,
        DREQ = 2'd2
    } state_t;

    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;
    localparam logic [7:0] TO_C      = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ccerr_q, ccerr_d;
    logic        d_req_s;
    logic        d_first_s;
    logic        owner_req_s;
    logic        done_s;
    logic        go_idle_s;
    logic [31:0] xfer_s;

    assign d_req_s = dREN | dWEN;

`ifdef ARB_FAIRNESS_EN
    logic last_d_q, last_d_d;
    // With fairness, a pending instruction request beats data right after a data grant.
    assign d_first_s = d_req_s & ~(iREN & last_d_q);
`else
    assign d_first_s = d_req_s;
`endif

    // Next-state, grant capture and completion signalling.
    always_comb begin
        state_d   = state_q;
        ren_d     = ren_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        store_d   = store_q;
        cnt_d     = cnt_q;
        ccerr_d   = ccerr_q;
        done_s    = 1'b0;
        go_idle_s = 1'b0;
        xfer_s    = 32'd0;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = 32'd0;
        dload     = 32'd0;
`ifdef ARB_FAIRNESS_EN
        last_d_d  = last_d_q;
`endif
        owner_req_s = (state_q == IREQ) ? iREN : d_req_s;

        case (state_q)
            IDLE: begin
                if (d_first_s) begin
                    state_d = DREQ;
                    ren_d   = ~dWEN;
                    wen_d   = dWEN;
                    addr_d  = daddr;
                    store_d = dWEN ? dstore : 32'd0;
                    cnt_d   = 8'd0;
`ifdef ARB_FAIRNESS_EN
                    last_d_d = 1'b1;
`endif
                end else if (iREN) begin
                    state_d = IREQ;
                    ren_d   = 1'b1;
                    wen_d   = 1'b0;
                    addr_d  = iaddr;
                    store_d = 32'd0;
                    cnt_d   = 8'd0;
`ifdef ARB_FAIRNESS_EN
                    last_d_d = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            IREQ, DREQ: begin
                // A withdrawn request aborts silently, even if the RAM answers this cycle.
                if (!owner_req_s) begin
                    go_idle_s = 1'b1;
                end else if ((ramstate == RS_ACCESS) || (ramstate == RS_ERROR)) begin
                    done_s    = 1'b1;
                    go_idle_s = 1'b1;
                    xfer_s    = ramload;
                    ccerr_d   = ccerr_q | (ramstate == RS_ERROR);
                end else if (cnt_q >= TO_C) begin
                    done_s    = 1'b1;
                    go_idle_s = 1'b1;
                    xfer_s    = ERRWORD;
                    ccerr_d   = 1'b1;
                end else if ((ramstate == RS_BUSY) && (cnt_q != 8'hFF)) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                go_idle_s = 1'b1;
            end
        endcase

        if (go_idle_s) begin
            state_d = IDLE;
            ren_d   = 1'b0;
            wen_d   = 1'b0;
            addr_d  = 32'd0;
            store_d = 32'd0;
        end else begin
            state_d = state_d;
        end

        if (done_s && (state_q == IREQ)) begin
            iwait = 1'b0;
            iload = xfer_s;
        end else if (done_s && (state_q == DREQ)) begin
            dwait = 1'b0;
            dload = xfer_s;
        end else begin
            iwait = 1'b1;
            dwait = 1'b1;
        end
    end

    // State and registered RAM-side outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= 32'd0;
            store_q  <= 32'd0;
            cnt_q    <= 8'd0;
            ccerr_q  <= 1'b0;
`ifdef ARB_FAIRNESS_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            cnt_q    <= cnt_d;
            ccerr_q  <= ccerr_d;
`ifdef ARB_FAIRNESS_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign ccerr    = ccerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow ARB_FAIRNESS_EN when defined.
module tb_mem_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ccerr;

    int n_checks;
    int n_fails;

    mem_arbiter #(.TIMEOUT(64), .ERRWORD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ccerr(ccerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ren"},   {31'd0, ramREN}, 32'd0);
        chk({tag, "_wen"},   {31'd0, ramWEN}, 32'd0);
        chk({tag, "_addr"},  ramaddr, 32'd0);
        chk({tag, "_iwait"}, {31'd0, iwait}, 32'd1);
        chk({tag, "_dwait"}, {31'd0, dwait}, 32'd1);
    endtask

    initial begin
        logic exp_d;
        n_checks = 0;
        n_fails  = 0;
        nRST = 1'b0; iREN = 1'b0; iaddr = 32'd0; dREN = 1'b0; dWEN = 1'b0;
        daddr = 32'd0; dstore = 32'd0; ramload = 32'd0; ramstate = 2'd0;
        tick(); tick();
        #1;
        chk_idle("rst");
        chk("rst_store", ramstore, 32'd0);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_ccerr", {31'd0, ccerr}, 32'd0);
        nRST = 1'b1;

        // Instruction read: two BUSY cycles then ACCESS
        tick(); iREN = 1'b1; iaddr = 32'h100; ramstate = 2'd1; #1;
        chk("i_grant_cycle_ren", {31'd0, ramREN}, 32'd0);
        tick(); #1;
        chk("i_ireq_ren", {31'd0, ramREN}, 32'd1);
        chk("i_ireq_addr", ramaddr, 32'h100);
        chk("i_busy1_iwait", {31'd0, iwait}, 32'd1);
        tick(); #1;
        chk("i_busy2_iwait", {31'd0, iwait}, 32'd1);
        tick(); ramstate = 2'd2; ramload = 32'h8C220004; #1;
        chk("i_done_iwait", {31'd0, iwait}, 32'd0);
        chk("i_done_iload", iload, 32'h8C220004);
        chk("i_done_dwait", {31'd0, dwait}, 32'd1);
        chk("i_done_dload", dload, 32'd0);
        tick(); iREN = 1'b0; ramstate = 2'd0; #1;
        chk_idle("i_after");
        chk("i_after_iload", iload, 32'd0);

        // Simultaneous instruction read and data write: data first
        tick(); iREN = 1'b1; iaddr = 32'h300; dWEN = 1'b1; daddr = 32'h200;
        dstore = 32'hDEADBEEF; ramstate = 2'd2; ramload = 32'h0; #1;
        chk("dw_idle_dwait", {31'd0, dwait}, 32'd1);
        tick(); #1;
        chk("dw_wen", {31'd0, ramWEN}, 32'd1);
        chk("dw_ren", {31'd0, ramREN}, 32'd0);
        chk("dw_addr", ramaddr, 32'h200);
        chk("dw_store", ramstore, 32'hDEADBEEF);
        chk("dw_dwait", {31'd0, dwait}, 32'd0);
        chk("dw_iwait", {31'd0, iwait}, 32'd1);
        tick(); dWEN = 1'b0; #1;
        chk_idle("dw_gap");
        tick(); ramload = 32'h11112222; #1;
        chk("dw_i_ren", {31'd0, ramREN}, 32'd1);
        chk("dw_i_addr", ramaddr, 32'h300);
        chk("dw_i_iwait", {31'd0, iwait}, 32'd0);
        chk("dw_i_iload", iload, 32'h11112222);
        chk("dw_i_dwait", {31'd0, dwait}, 32'd1);
        tick(); iREN = 1'b0; #1;
        chk_idle("dw_end");

        // Both requesters held for four back-to-back transactions
        tick(); iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; daddr = 32'h400;
        ramload = 32'hA5A5A5A5; #1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_FAIRNESS_EN
            exp_d = ((k % 2) == 0);
`else
            exp_d = 1'b1;
`endif
            tick(); #1;
            chk("arb_dwait", {31'd0, dwait}, {31'd0, ~exp_d});
            chk("arb_iwait", {31'd0, iwait}, {31'd0, exp_d});
            chk("arb_addr", ramaddr, exp_d ? 32'h400 : 32'h500);
            tick(); #1;
            chk_idle("arb_gap");
        end
        iREN = 1'b0; dREN = 1'b0;
        tick(); #1;
        chk_idle("arb_end");

        // Data requester withdraws while RAM is busy: silent abort
        tick(); dREN = 1'b1; daddr = 32'h600; ramstate = 2'd1; #1;
        tick(); #1;
        chk("wd_ren", {31'd0, ramREN}, 32'd1);
        tick(); dREN = 1'b0; ramstate = 2'd2; #1;
        chk("wd_dwait", {31'd0, dwait}, 32'd1);
        tick(); ramstate = 2'd0; #1;
        chk_idle("wd_after");
        chk("wd_ccerr", {31'd0, ccerr}, 32'd0);

        // RAM ERROR completes the access and sets the sticky flag
        tick(); iREN = 1'b1; iaddr = 32'h800; ramstate = 2'd3; ramload = 32'h5555AAAA; #1;
        tick(); #1;
        chk("err_iwait", {31'd0, iwait}, 32'd0);
        chk("err_iload", iload, 32'h5555AAAA);
        chk("err_ccerr_pre", {31'd0, ccerr}, 32'd0);
        tick(); iREN = 1'b0; ramstate = 2'd0; #1;
        chk("err_ccerr", {31'd0, ccerr}, 32'd1);
        tick(); #1;
        chk("err_ccerr_sticky", {31'd0, ccerr}, 32'd1);

        // Reset in the middle of a data write
        tick(); dWEN = 1'b1; daddr = 32'h900; dstore = 32'h12345678; ramstate = 2'd1; #1;
        tick(); #1;
        chk("rm_wen", {31'd0, ramWEN}, 32'd1);
        chk("rm_store", ramstore, 32'h12345678);
        nRST = 1'b0; ramstate = 2'd2; #1;
        chk_idle("rm_inrst");
        chk("rm_store0", ramstore, 32'd0);
        chk("rm_ccerr", {31'd0, ccerr}, 32'd0);
        dWEN = 1'b0; ramstate = 2'd0;
        tick(); nRST = 1'b1; #1;
        tick(); #1;
        chk_idle("rm_after");

        // RAM stuck BUSY: abort after TIMEOUT cycles with the error word
        tick(); dREN = 1'b1; daddr = 32'h700; ramstate = 2'd1; #1;
        for (int i = 1; i <= 64; i++) begin
            tick(); #1;
            chk("to_busy_dwait", {31'd0, dwait}, 32'd1);
        end
        tick(); #1;
        chk("to_dwait", {31'd0, dwait}, 32'd0);
        chk("to_dload", dload, 32'hBAD1BAD1);
        tick(); dREN = 1'b0; ramstate = 2'd0; #1;
        chk("to_ccerr", {31'd0, ccerr}, 32'd1);
        chk_idle("to_after");
        tick(); #1;
        chk("to_ccerr_sticky", {31'd0, ccerr}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
